// File: rtl/rr_lock_arbiter_if.sv
// rr_lock_arbiter_if
//   Request/grant bundle between N clients and the round-robin lock arbiter.
//   Parameter N is the number of requesters. IDX_W is derived from N and
//   must match the arbiter's own IDX_W.
//   Signals:
//     req     [N-1:0]     level-sensitive request, bit i = requester i
//     lock    [N-1:0]     requester i asks to keep its current grant
//     gnt     [N-1:0]     registered one-hot grant, zero when idle
//     gnt_idx [IDX_W-1:0] binary index of the granted requester, 0 when idle
//     gnt_vld             high whenever gnt is non-zero
//   Modports:
//     master  client side: drives req/lock and observes the grant
//     slave   arbiter side: samples req/lock and drives the grant
interface rr_lock_arbiter_if #(
  parameter int N = 4
);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]     req;
  logic [N-1:0]     lock;
  logic [N-1:0]     gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_vld;

  modport master (
    output req,
    output lock,
    input  gnt,
    input  gnt_idx,
    input  gnt_vld
  );

  modport slave (
    input  req,
    input  lock,
    output gnt,
    output gnt_idx,
    output gnt_vld
  );
endinterface

// File: rtl/rr_lock_arbiter.sv
// rr_lock_arbiter
//   Round-robin arbiter for N requesters with a registered one-hot grant.
//   Priority rotates to the requester after the last winner. The current
//   holder may keep the grant by asserting its lock bit, for at most
//   HOLD_MAX consecutive cycles; after that it must re-arbitrate.
//   Parameters:
//     N        number of requesters (>= 2, any value)
//     HOLD_MAX maximum consecutive grant cycles of a locked holder (>= 1)
//   Ports:
//     clk  single rising-edge clock
//     rst  synchronous active-high reset
//     bus  rr_lock_arbiter_if slave modport (req, lock in; gnt, gnt_idx,
//          gnt_vld out). All outputs come straight from registers.
module rr_lock_arbiter #(
  parameter int N        = 4,
  parameter int HOLD_MAX = 8
) (
  input  logic               clk,
  input  logic               rst,
  rr_lock_arbiter_if.slave   bus
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = $clog2(HOLD_MAX + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Scan ptr, ptr+1, ..., N-1, 0, ..., ptr-1 and return {found, index} of
  // the first active request. The modulo is done on an int so that a
  // non-power-of-two N wraps at N, never at 2**IDX_W.
  function automatic logic [IDX_W:0] rr_pick(
    input logic [N-1:0]     r,
    input logic [IDX_W-1:0] p
  );
    logic             found;
    logic [IDX_W-1:0] w;
    int               c;
    found = 1'b0;
    w     = '0;
    for (int i = 0; i < N; i++) begin
      c = int'(p) + i;
      if (c >= N) c = c - N;
      if (!found && r[c]) begin
        found = 1'b1;
        w     = IDX_W'(c);
      end
    end
    return {found, w};
  endfunction

  function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] w);
    return (w == IDX_W'(N - 1)) ? '0 : w + IDX_W'(1);
  endfunction

  function automatic logic [N-1:0] to_onehot(input logic [IDX_W-1:0] w);
    logic [N-1:0] v;
    v    = '0;
    v[w] = 1'b1;
    return v;
  endfunction

  state_t           state_p1, state_nxt;
  logic [IDX_W-1:0] ptr_p1, ptr_nxt;
  logic [CNT_W-1:0] hold_p1, hold_nxt;
  logic [N-1:0]     gnt_p1, gnt_nxt;
  logic [IDX_W-1:0] gnt_idx_p1, gnt_idx_nxt;

  logic             win_vld_p0;
  logic [IDX_W-1:0] win_idx_p0;
  logic             keep_p0;

  // Stage p0: combinational arbitration on the sampled req/lock
  always_comb begin
    {win_vld_p0, win_idx_p0} = rr_pick(bus.req, ptr_p1);
    keep_p0 = (state_p1 == GRANT) && bus.req[gnt_idx_p1] &&
              bus.lock[gnt_idx_p1] && (hold_p1 < CNT_W'(HOLD_MAX));
  end

  always_comb begin
    state_nxt   = state_p1;
    ptr_nxt     = ptr_p1;
    hold_nxt    = hold_p1;
    gnt_nxt     = gnt_p1;
    gnt_idx_nxt = gnt_idx_p1;
    unique case (state_p1)
      IDLE: begin
        if (win_vld_p0) begin
          state_nxt   = GRANT;
          ptr_nxt     = ptr_after(win_idx_p0);
          hold_nxt    = CNT_W'(1);
          gnt_nxt     = to_onehot(win_idx_p0);
          gnt_idx_nxt = win_idx_p0;
        end
      end
      GRANT: begin
        if (keep_p0) begin
          hold_nxt = hold_p1 + CNT_W'(1);
        end else if (win_vld_p0) begin
          // ptr already points past the holder, so the holder only wins
          // again when it is the sole requester.
          ptr_nxt     = ptr_after(win_idx_p0);
          hold_nxt    = CNT_W'(1);
          gnt_nxt     = to_onehot(win_idx_p0);
          gnt_idx_nxt = win_idx_p0;
        end else begin
          state_nxt   = IDLE;
          hold_nxt    = '0;
          gnt_nxt     = '0;
          gnt_idx_nxt = '0;
        end
      end
      default: begin
        state_nxt   = IDLE;
        ptr_nxt     = '0;
        hold_nxt    = '0;
        gnt_nxt     = '0;
        gnt_idx_nxt = '0;
      end
    endcase
  end

  // Stage p1: registered grant and arbitration state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1   <= IDLE;
      ptr_p1     <= '0;
      hold_p1    <= '0;
      gnt_p1     <= '0;
      gnt_idx_p1 <= '0;
    end else begin
      state_p1   <= state_nxt;
      ptr_p1     <= ptr_nxt;
      hold_p1    <= hold_nxt;
      gnt_p1     <= gnt_nxt;
      gnt_idx_p1 <= gnt_idx_nxt;
    end
  end

  assign bus.gnt     = gnt_p1;
  assign bus.gnt_idx = gnt_idx_p1;
  assign bus.gnt_vld = (state_p1 == GRANT);

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// tb_rr_lock_arbiter
//   Three arbiter instances: A (N=4, HOLD_MAX=4), B (N=5, HOLD_MAX=8) and
//   C (N=3, HOLD_MAX=1). Stimulus tasks drive one cycle of req/lock/rst
//   on the falling edge and queue the hand-computed grant expected after
//   the following rising edge; one monitor per instance pops and compares.
module tb_rr_lock_arbiter;

  typedef struct packed {
    logic [4:0] g;
    logic [2:0] i;
    logic       v;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
  int   checks = 0;
  int   errors = 0;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  always #5 clk = ~clk;

  rr_lock_arbiter_if #(.N(4)) ifa ();
  rr_lock_arbiter_if #(.N(5)) ifb ();
  rr_lock_arbiter_if #(.N(3)) ifc ();

  rr_lock_arbiter #(.N(4), .HOLD_MAX(4)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa.slave));
  rr_lock_arbiter #(.N(5), .HOLD_MAX(8)) dut_b (.clk(clk), .rst(rst_b), .bus(ifb.slave));
  rr_lock_arbiter #(.N(3), .HOLD_MAX(1)) dut_c (.clk(clk), .rst(rst_c), .bus(ifc.slave));

  function automatic exp_t mk(input logic [4:0] g);
    exp_t e;
    e.g = g;
    e.i = 3'd0;
    e.v = |g;
    for (int k = 0; k < 5; k++) if (g[k]) e.i = 3'(k);
    return e;
  endfunction

  task automatic check(input string name, input exp_t act, input exp_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s #%0d: got gnt=%b idx=%0d vld=%b, expected gnt=%b idx=%0d vld=%b",
               name, checks, act.g, act.i, act.v, exp.g, exp.i, exp.v);
    end
  endtask

  task automatic step_a(input logic r, input logic [3:0] rq, input logic [3:0] lk,
                        input logic [3:0] eg);
    @(negedge clk);
    rst_a = r; ifa.req = rq; ifa.lock = lk;
    qa.push_back(mk({1'b0, eg}));
  endtask

  task automatic step_b(input logic r, input logic [4:0] rq, input logic [4:0] lk,
                        input logic [4:0] eg);
    @(negedge clk);
    rst_b = r; ifb.req = rq; ifb.lock = lk;
    qb.push_back(mk(eg));
  endtask

  task automatic step_c(input logic r, input logic [2:0] rq, input logic [2:0] lk,
                        input logic [2:0] eg);
    @(negedge clk);
    rst_c = r; ifc.req = rq; ifc.lock = lk;
    qc.push_back(mk({2'b0, eg}));
  endtask

  always @(posedge clk) begin
    #1;
    if (qa.size() > 0) check("A", {1'b0, ifa.gnt, 1'b0, ifa.gnt_idx, ifa.gnt_vld}, qa.pop_front());
    if (qb.size() > 0) check("B", {ifb.gnt, ifb.gnt_idx, ifb.gnt_vld}, qb.pop_front());
    if (qc.size() > 0) check("C", {2'b0, ifc.gnt, 1'b0, ifc.gnt_idx, ifc.gnt_vld}, qc.pop_front());
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    ifa.req = '0; ifa.lock = '0;
    ifb.req = '0; ifb.lock = '0;
    ifc.req = '0; ifc.lock = '0;

    // A: reset priority, outputs zero during reset
    repeat (3) step_a(1'b1, 4'b1111, 4'b0000, 4'b0000);
    step_a(1'b0, 4'b1111, 4'b0000, 4'b0001);
    step_a(1'b0, 4'b1111, 4'b0000, 4'b0010);
    step_a(1'b0, 4'b1111, 4'b0000, 4'b0100);
    step_a(1'b0, 4'b1111, 4'b0000, 4'b1000);
    step_a(1'b0, 4'b1111, 4'b0000, 4'b0001);
    step_a(1'b1, 4'b0000, 4'b0000, 4'b0000);
    // A: sparse rotation from ptr=0
    step_a(1'b0, 4'b1010, 4'b0000, 4'b0010);
    step_a(1'b0, 4'b1010, 4'b0000, 4'b1000);
    step_a(1'b0, 4'b1010, 4'b0000, 4'b0010);
    step_a(1'b0, 4'b1010, 4'b0000, 4'b1000);
    // A: lock with max hold 4
    repeat (4) step_a(1'b0, 4'b0101, 4'b0001, 4'b0001);
    step_a(1'b0, 4'b0101, 4'b0001, 4'b0100);
    repeat (4) step_a(1'b0, 4'b0101, 4'b0001, 4'b0001);
    step_a(1'b0, 4'b0101, 4'b0001, 4'b0100);
    // A: holder 2 locked, then releases with nobody else requesting
    step_a(1'b0, 4'b0100, 4'b0100, 4'b0100);
    step_a(1'b0, 4'b0100, 4'b0100, 4'b0100);
    step_a(1'b0, 4'b0000, 4'b0100, 4'b0000);
    // A: lone locked requester, hold counter restarts at 1 after expiry
    repeat (6) step_a(1'b0, 4'b0100, 4'b0100, 4'b0100);
    step_a(1'b0, 4'b0101, 4'b0100, 4'b0100);
    step_a(1'b0, 4'b0101, 4'b0100, 4'b0100);
    step_a(1'b0, 4'b0101, 4'b0100, 4'b0001);
    step_a(1'b0, 4'b0101, 4'b0100, 4'b0100);
    // A: lock bits of non-holders are ignored
    step_a(1'b0, 4'b1111, 4'b1011, 4'b1000);
    step_a(1'b0, 4'b1111, 4'b0111, 4'b0001);
    // A: reset in the middle of a locked burst (hold_cnt=2)
    step_a(1'b0, 4'b0001, 4'b0001, 4'b0001);
    step_a(1'b1, 4'b1111, 4'b1111, 4'b0000);
    step_a(1'b0, 4'b1111, 4'b0000, 4'b0001);
    step_a(1'b0, 4'b1111, 4'b0000, 4'b0010);

    // B: N=5 wrap
    repeat (2) step_b(1'b1, 5'b00000, 5'b00000, 5'b00000);
    step_b(1'b0, 5'b10001, 5'b00000, 5'b00001);
    step_b(1'b0, 5'b10001, 5'b00000, 5'b10000);
    step_b(1'b0, 5'b10001, 5'b00000, 5'b00001);
    step_b(1'b0, 5'b10001, 5'b00000, 5'b10000);
    step_b(1'b0, 5'b11111, 5'b00000, 5'b00001);
    step_b(1'b0, 5'b11111, 5'b00000, 5'b00010);
    step_b(1'b0, 5'b11111, 5'b00000, 5'b00100);
    step_b(1'b0, 5'b11111, 5'b00000, 5'b01000);
    step_b(1'b0, 5'b11111, 5'b00000, 5'b10000);
    step_b(1'b0, 5'b11111, 5'b00000, 5'b00001);
    step_b(1'b0, 5'b00000, 5'b00000, 5'b00000);

    // C: HOLD_MAX=1 makes lock ineffective
    repeat (2) step_c(1'b1, 3'b000, 3'b000, 3'b000);
    step_c(1'b0, 3'b011, 3'b011, 3'b001);
    step_c(1'b0, 3'b011, 3'b011, 3'b010);
    step_c(1'b0, 3'b011, 3'b011, 3'b001);
    step_c(1'b0, 3'b011, 3'b011, 3'b010);
    step_c(1'b0, 3'b100, 3'b100, 3'b100);
    step_c(1'b0, 3'b100, 3'b100, 3'b100);
    step_c(1'b0, 3'b111, 3'b000, 3'b001);

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (qa.size() + qb.size() + qc.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left unchecked, expected 0",
               qa.size() + qb.size() + qc.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
